// File: rtl/serial_pkg.sv
// Shared definitions for the serial packet transmitter: state encoding, frame sizing, line levels.
// The CHECK state exists only when SERIAL_TX_PACKET_CHECKSUM_EN is defined.
package serial_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
    , StCheck
`endif
  } txState_e;

  localparam logic IdleLevel = 1'b1;
  localparam logic StartLevel = ~IdleLevel;
  localparam int unsigned FrameOverhead = 2;

  // Start bit + data bits + stop bit.
  function automatic int unsigned frameBits(int unsigned wordWidth);
    return wordWidth + FrameOverhead;
  endfunction

  // Two's-complement negation; callers truncate to their word width.
  function automatic logic [31:0] checksumNegate(logic [31:0] sum);
    return ~sum + 32'd1;
  endfunction

endpackage

// File: rtl/serial_tx_shifter.sv
// Single UART frame serialiser: start bit, WordWidth data bits LSB first, stop bit.
// A start strobe always reloads, which lets the next frame begin on the edge the last one ends.
module serial_tx_shifter
  import serial_pkg::*;
#(
  parameter int unsigned WordWidth = 8,
  parameter int unsigned SerialTimerWidth = 8,
  parameter int unsigned BitPeriod = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WordWidth-1:0] word,
  output logic                 tx,
  output logic                 bitDone,
  output logic                 frameDone
);

  localparam int unsigned FrameLen = frameBits(WordWidth);
  localparam int unsigned CntWidth = $clog2(FrameLen);
  localparam logic [SerialTimerWidth-1:0] TimerLast = SerialTimerWidth'(BitPeriod - 1);
  localparam logic [CntWidth-1:0] LastBit = CntWidth'(FrameLen - 1);

  logic [SerialTimerWidth-1:0] timerQ;
  logic [CntWidth-1:0]         bitCntQ;
  logic [WordWidth:0]          shiftQ;  // bits still to send after the current one
  logic                        activeQ;
  logic                        txQ;

  assign bitDone   = activeQ && (timerQ == TimerLast);
  assign frameDone = bitDone && (bitCntQ == LastBit);
  assign tx        = txQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timerQ  <= '0;
      bitCntQ <= '0;
      shiftQ  <= '0;
      activeQ <= 1'b0;
      txQ     <= IdleLevel;
    end else if (start) begin
      timerQ  <= '0;
      bitCntQ <= '0;
      shiftQ  <= {IdleLevel, word};
      activeQ <= 1'b1;
      txQ     <= StartLevel;
    end else if (bitDone) begin
      timerQ <= '0;
      if (frameDone) begin
        activeQ <= 1'b0;
      end else begin
        bitCntQ <= bitCntQ + CntWidth'(1);
        txQ     <= shiftQ[0];
        shiftQ  <= {IdleLevel, shiftQ[WordWidth:1]};
      end
    end else if (activeQ) begin
      timerQ <= timerQ + SerialTimerWidth'(1);
    end
  end

endmodule

// File: rtl/serial_tx_packet.sv
// Packet transmitter: latches up to 2**AddressWidth words and sends them as back-to-back frames.
// Define SERIAL_TX_PACKET_CHECKSUM_EN to append a frame carrying the negated word sum.
module serial_tx_packet
  import serial_pkg::*;
#(
  parameter int unsigned AddressWidth = 2,
  parameter int unsigned WordWidth = 8,
  parameter int unsigned SerialTimerWidth = 8,
  parameter int unsigned BitPeriod = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ce,
  input  logic [(2**AddressWidth)*WordWidth-1:0] data,
  input  logic [AddressWidth-1:0]               count,
  output logic                                  tx,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned DataWidth = (2**AddressWidth) * WordWidth;
  localparam int unsigned BitIdxWidth = (WordWidth > 1) ? $clog2(WordWidth) : 1;
  localparam logic [BitIdxWidth-1:0] LastDataBit = BitIdxWidth'(WordWidth - 1);

  txState_e                stateQ, stateD;
  logic [AddressWidth-1:0] idxQ, idxD, nextIdx;
  logic [BitIdxWidth-1:0]  bitIdxQ, bitIdxD;
  logic [AddressWidth-1:0] countQ;
  logic [DataWidth-1:0]    dataQ;
  logic                    busyQ, busyD;
  logic                    doneQ, doneD;
  logic                    accept;
  logic                    shStart;
  logic [WordWidth-1:0]    shWord, nextWord;
  logic                    bitDone, frameDone;
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
  logic [WordWidth-1:0]    csumQ, csumD;
`endif

  assign accept   = (stateQ == StIdle) && ce;
  assign nextIdx  = idxQ + AddressWidth'(1);
  assign nextWord = dataQ[nextIdx*WordWidth +: WordWidth];
  assign busy     = busyQ;
  assign done     = doneQ;

  always_comb begin
    stateD  = stateQ;
    idxD    = idxQ;
    bitIdxD = bitIdxQ;
    busyD   = busyQ;
    doneD   = 1'b0;
    shStart = 1'b0;
    shWord  = nextWord;
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
    csumD   = csumQ;
`endif
    case (stateQ)
      StIdle: begin
        if (ce) begin
          stateD  = StStart;
          idxD    = '0;
          busyD   = 1'b1;
          shStart = 1'b1;
          shWord  = data[WordWidth-1:0];
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
          csumD   = data[WordWidth-1:0];
`endif
        end
      end
      StStart: begin
        if (bitDone) begin
          stateD  = StData;
          bitIdxD = '0;
        end
      end
      StData: begin
        if (bitDone) begin
          if (bitIdxQ == LastDataBit) begin
            stateD = StStop;
          end else begin
            bitIdxD = bitIdxQ + BitIdxWidth'(1);
          end
        end
      end
      StStop: begin
        if (frameDone) begin
          // Both sides are AddressWidth bits, so count at its maximum cannot wrap.
          if (idxQ < countQ) begin
            stateD  = StStart;
            idxD    = nextIdx;
            shStart = 1'b1;
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
            csumD   = csumQ + nextWord;
`endif
          end else begin
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
            stateD  = StCheck;
            shStart = 1'b1;
            shWord  = WordWidth'(checksumNegate(32'(csumQ)));
`else
            stateD  = StIdle;
            busyD   = 1'b0;
            doneD   = 1'b1;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
      StCheck: begin
        if (frameDone) begin
          stateD = StIdle;
          busyD  = 1'b0;
          doneD  = 1'b1;
        end
      end
`endif
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ  <= StIdle;
      idxQ    <= '0;
      bitIdxQ <= '0;
      countQ  <= '0;
      dataQ   <= '0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
      csumQ   <= '0;
`endif
    end else begin
      stateQ  <= stateD;
      idxQ    <= idxD;
      bitIdxQ <= bitIdxD;
      busyQ   <= busyD;
      doneQ   <= doneD;
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
      csumQ   <= csumD;
`endif
      if (accept) begin
        dataQ  <= data;
        countQ <= count;
      end
    end
  end

  serial_tx_shifter #(
    .WordWidth       (WordWidth),
    .SerialTimerWidth(SerialTimerWidth),
    .BitPeriod       (BitPeriod)
  ) uShifter (
    .clk      (clk),
    .rst      (rst),
    .start    (shStart),
    .word     (shWord),
    .tx       (tx),
    .bitDone  (bitDone),
    .frameDone(frameDone)
  );

endmodule

// File: doc/serial_tx_packet.md
Name: serial_tx_packet

Overview:
Parametrised successor to the fixed-length serial packet transmitter. Latches a packet of 1..2**AddressWidth words plus a run-time word count in one strobe. Transmits the words back-to-back as 8N1-style UART frames on one line, with no idle gap between frames. Sits between a result/telemetry producer and the board UART pin, and reports completion with a one-cycle done pulse.

Parameters:
AddressWidth, 2, log2 of maximum words per packet
WordWidth, 8, data bits per UART frame
SerialTimerWidth, 8, width of the bit-period timer
BitPeriod, 16, clocks per serial bit; legal range 2..2**SerialTimerWidth-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
ce  input  1  load strobe; sampled only while busy==0
data  input  2**AddressWidth*WordWidth  packet words; word k = data[k*WordWidth +: WordWidth]
count  input  AddressWidth  number of words to send minus 1; sampled with ce
tx  output  1  serial line; idle high
busy  output  1  high from packet accept until the last stop bit ends
done  output  1  one-cycle pulse when the packet completes

Behaviour:
- Reset (async, immediate): tx=1, busy=0, done=0, FSM=IDLE, word index=0, bit counter=0, timer=0, data buffer=0, checksum=0.
- Frame format: one start bit (0), then WordWidth data bits LSB first, then one stop bit (1). Each bit holds exactly BitPeriod clocks. One frame = (WordWidth+2)*BitPeriod clocks.
- FSM states: IDLE, START, DATA, STOP, CHECK (CHECKSUM_EN only).
- IDLE with ce=1 (sampled at an edge):
  - data and count are latched; word index=0; checksum=0.
  - busy<=1 and tx<=0 on that same edge, and the FSM goes to START.
  - Latency from the ce edge to the start bit is zero cycles.
- START: after BitPeriod clocks, go to DATA with bit index 0.
- DATA: shift out one bit per BitPeriod; after bit WordWidth-1, go to STOP.
- STOP: after BitPeriod clocks:
  - If word index < latched count: index+1 and go directly to START, so the next start bit follows with no idle cycle.
  - Otherwise go to CHECK if CHECKSUM_EN is defined; else go to IDLE with busy<=0, done<=1 and tx=1.
- done is high for exactly one cycle, on the edge where busy falls.
- Total busy time = (count+1[+1 with checksum])*(WordWidth+2)*BitPeriod clocks.
- ce while busy==1: ignored entirely; it is not queued, and data and count are not re-latched.
- ce in the cycle where done=1: busy is already 0, so the strobe is accepted and a new packet starts on that edge.
- Input changes after the accept edge have no effect on the packet in flight.
- count = 2**AddressWidth-1 sends all words; the index compare must not wrap.
- Reset mid-frame: tx returns high asynchronously and the partial frame is abandoned. No done pulse is generated.

Optional Feature:
Macro SERIAL_TX_PACKET_CHECKSUM_EN.
- Defined: a running sum modulo 2**WordWidth accumulates each word as it is loaded. After the last data frame, one extra frame in state CHECK carries the two's-complement negation of that sum, so that all transmitted words sum to 0 mod 2**WordWidth. busy and done are then driven after the checksum frame's stop bit.
- Undefined: no checksum register, no CHECK state, and timing equals the data frames only.

Decomposition:
- Shared header serial_pkg:
  - FSM state encodings
  - frame-length constant (WordWidth+2)
  - idle-line level
  - checksum helper function
- One natural sub-module: serial_tx_shifter. It takes a word, a start strobe and BitPeriod, and outputs tx, bit_done and frame_done. serial_tx_packet owns only word sequencing, checksum and the packet handshake.

Test Plan:
- Reset while idle: tx=1, busy=0, done=0 held for 20 cycles.
- AW=2, W=8, BitPeriod=4, count=0, data word0=8'hA5, no checksum → tx samples at bit centres read 0,1,0,1,0,0,1,0,1,1; busy high exactly 40 cycles; done pulses once at cycle 40.
- count=3, words 8'h01,8'h02,8'h03,8'h04 → four frames back-to-back, 160 busy cycles, decoded bytes in order 01,02,03,04, no idle bit between frames.
- CHECKSUM_EN, same 4 words → fifth frame carries 8'hF6 (sum 0x0A negated); busy 200 cycles.
- ce pulsed at cycles 10 and 25 of an active packet → only the first packet is sent. ce in the done cycle → second packet starts on that edge with zero idle.
- rst asserted at cycle 17 mid-frame → tx=1 and busy=0 immediately, with no done pulse. A new ce after release sends a correct full packet.
